i2c_bus_scheduler: RTL and testbench

Round-robin transaction scheduler that shares one `i2c_master` instance between up to NUM_REQ requesters (sensor pollers, config writers) in the i2cbus plugin. It latches one request at a time, drives the master's start/address/rw/bytes/data inputs, tracks the master's busy handshake to completion, and returns read data plus a per-requester done pulse. It runs in the system `clk` domain and treats the master's status outputs as asynchronous.

---
 rtl/i2c_sched_pkg.sv | 13 +
 rtl/i2c_sched_rr_arbiter.sv | 26 ++
 rtl/i2c_bus_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_i2c_bus_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_sched_pkg.sv
// i2c_sched_pkg: shared widths, FSM state type and byte-count clamp for the I2C bus scheduler
package i2c_sched_pkg;
    localparam int ADDR_W    = 7;
    localparam int BYTES_W   = 5;
    localparam int DATA_W    = 32;
    localparam int MAX_BYTES = 4;

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} sched_state_e;

    function automatic logic [BYTES_W-1:0] clamp_bytes(input logic [BYTES_W-1:0] b);
        return (b > BYTES_W'(MAX_BYTES)) ? BYTES_W'(MAX_BYTES) : b;
    endfunction
endpackage

// File: rtl/i2c_sched_rr_arbiter.sv
// i2c_sched_rr_arbiter: combinational round-robin pick of the first set request at or after ptr
module i2c_sched_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any_req
);
    logic [IDX_W-1:0] idx;

    // walk slots upward from ptr with wrap-around, first hit wins
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        idx     = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_req && req[idx]) begin
                grant   = idx;
                any_req = 1'b1;
            end
            idx = (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: rtl/i2c_bus_scheduler.sv
// i2c_bus_scheduler: round-robin sharing of one i2c_master; optional abort timer via I2C_BUS_SCHEDULER_TIMEOUT_EN
module i2c_bus_scheduler
    import i2c_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*7-1:0]   req_addr,
    input  logic [NUM_REQ-1:0]     req_rw,
    input  logic [NUM_REQ*5-1:0]   req_bytes,
    input  logic [NUM_REQ*32-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [NUM_REQ-1:0]     done,
    output logic [31:0]            rdata,
    output logic                   rd_valid,
    output logic                   timeout_err,
    output logic                   m_start,
    output logic [6:0]             m_addr,
    output logic                   m_rw,
    output logic [4:0]             m_bytes,
    output logic [31:0]            m_wdata,
    input  logic                   m_busy,
    input  logic                   m_valid,
    input  logic [31:0]            m_data_in
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 1 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("i2c_bus_scheduler: NUM_REQ must be 1..8 and TIMEOUT_CYCLES >= 1");
    end

    sched_state_e         state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d, gnt_q, gnt_d, arb_idx;
    logic                 arb_any, grant_en, tmo;
    logic                 busy_meta_q, busy_s_q, valid_meta_q, valid_s_q;
    logic                 m_start_q, m_start_d, m_rw_q, m_rw_d;
    logic [ADDR_W-1:0]    m_addr_q, m_addr_d;
    logic [BYTES_W-1:0]   m_bytes_q, m_bytes_d;
    logic [DATA_W-1:0]    m_wdata_q, m_wdata_d, rdata_q, rdata_d;
    logic [NUM_REQ-1:0]   req_ack_q, req_ack_d, done_q, done_d, gnt_oh;
    logic                 rd_valid_q, rd_valid_d, timeout_err_q, timeout_err_d;

    i2c_sched_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .grant   (arb_idx),
        .any_req (arb_any)
    );

    assign grant_en = (state_q == IDLE) && !busy_s_q && arb_any;
    assign gnt_oh   = NUM_REQ'(1) << gnt_q;

    // master status is asynchronous; keep tracking it through reset so IDLE sees a live busy
    always_ff @(posedge clk) begin
        busy_meta_q  <= m_busy;
        busy_s_q     <= busy_meta_q;
        valid_meta_q <= m_valid;
        valid_s_q    <= valid_meta_q;
    end

`ifdef I2C_BUS_SCHEDULER_TIMEOUT_EN
    logic [31:0] tmo_cnt_q, tmo_cnt_d;

    // per-transaction cycle budget, restarted on every grant
    always_comb begin
        tmo_cnt_d = grant_en ? '0 : (state_q == LAUNCH || state_q == RUN) ? tmo_cnt_q + 32'd1 : tmo_cnt_q;
    end

    assign tmo = (state_q == LAUNCH || state_q == RUN) && (tmo_cnt_q + 32'd1 == 32'(TIMEOUT_CYCLES));

    // timeout counter register
    always_ff @(posedge clk) begin
        if (!rst_n) tmo_cnt_q <= '0;
        else        tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign tmo = 1'b0;
`endif

    // grant, launch, wait for the master, then report; completion outputs are registered on entry to DONE
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        gnt_d         = gnt_q;
        m_addr_d      = m_addr_q;
        m_rw_d        = m_rw_q;
        m_bytes_d     = m_bytes_q;
        m_wdata_d     = m_wdata_q;
        m_start_d     = 1'b0;
        req_ack_d     = '0;
        done_d        = '0;
        rdata_d       = '0;
        rd_valid_d    = 1'b0;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_en) begin
                    state_d   = LAUNCH;
                    gnt_d     = arb_idx;
                    ptr_d     = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    m_addr_d  = req_addr[ADDR_W*arb_idx +: ADDR_W];
                    m_rw_d    = req_rw[arb_idx];
                    m_bytes_d = clamp_bytes(req_bytes[BYTES_W*arb_idx +: BYTES_W]);
                    m_wdata_d = req_wdata[DATA_W*arb_idx +: DATA_W];
                    req_ack_d = NUM_REQ'(1) << arb_idx;
                end
            end
            LAUNCH: begin
                if (tmo) begin
                    state_d       = DONE;
                    done_d        = gnt_oh;
                    timeout_err_d = 1'b1;
                end else if (busy_s_q) begin
                    state_d = RUN;
                end else begin
                    m_start_d = 1'b1;
                end
            end
            RUN: begin
                if (tmo) begin
                    state_d       = DONE;
                    done_d        = gnt_oh;
                    timeout_err_d = 1'b1;
                end else if (!busy_s_q) begin
                    state_d    = DONE;
                    done_d     = gnt_oh;
                    rdata_d    = m_rw_q ? m_data_in : '0;
                    rd_valid_d = m_rw_q & valid_s_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            gnt_q         <= '0;
            m_start_q     <= 1'b0;
            m_addr_q      <= '0;
            m_rw_q        <= 1'b0;
            m_bytes_q     <= '0;
            m_wdata_q     <= '0;
            req_ack_q     <= '0;
            done_q        <= '0;
            rdata_q       <= '0;
            rd_valid_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            gnt_q         <= gnt_d;
            m_start_q     <= m_start_d;
            m_addr_q      <= m_addr_d;
            m_rw_q        <= m_rw_d;
            m_bytes_q     <= m_bytes_d;
            m_wdata_q     <= m_wdata_d;
            req_ack_q     <= req_ack_d;
            done_q        <= done_d;
            rdata_q       <= rdata_d;
            rd_valid_q    <= rd_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign req_ack     = req_ack_q;
    assign done        = done_q;
    assign rdata       = rdata_q;
    assign rd_valid    = rd_valid_q;
    assign timeout_err = timeout_err_q;
    assign m_start     = m_start_q;
    assign m_addr      = m_addr_q;
    assign m_rw        = m_rw_q;
    assign m_bytes     = m_bytes_q;
    assign m_wdata     = m_wdata_q;
endmodule

// File: tb/tb_i2c_bus_scheduler.sv
// tb_i2c_bus_scheduler: table, directed and randomized checks of i2c_bus_scheduler against a behavioural model
module tb_i2c_bus_scheduler;
    localparam int N   = 4;
    localparam int TMO = 100;

    logic            clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0]    req = '0, req_rw = '0;
    logic [N*7-1:0]  req_addr = '0;
    logic [N*5-1:0]  req_bytes = '0;
    logic [N*32-1:0] req_wdata = '0;
    logic [N-1:0]    req_ack, done;
    logic [31:0]     rdata, m_wdata, m_data_in;
    logic            rd_valid, timeout_err, m_start, m_rw, m_busy, m_valid;
    logic [6:0]      m_addr;
    logic [4:0]      m_bytes;

    i2c_bus_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_rw(req_rw),
        .req_bytes(req_bytes), .req_wdata(req_wdata), .req_ack(req_ack), .done(done),
        .rdata(rdata), .rd_valid(rd_valid), .timeout_err(timeout_err), .m_start(m_start),
        .m_addr(m_addr), .m_rw(m_rw), .m_bytes(m_bytes), .m_wdata(m_wdata),
        .m_busy(m_busy), .m_valid(m_valid), .m_data_in(m_data_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // behavioural i2c_master: busy rises mst_dly cycles after start, lasts mst_len cycles
    int          mst_dly = 1, mst_len = 4, rise_cyc = 0, fall_cyc = 0;
    logic [31:0] mst_rd = '0;
    logic        mst_vld = 1'b1;
    initial begin
        m_busy = 1'b0; m_valid = 1'b0; m_data_in = '0;
        forever begin
            @(negedge clk);
            if (m_start && !m_busy) begin
                repeat (mst_dly) @(negedge clk);
                m_busy = 1'b1; m_valid = 1'b0; rise_cyc = cyc;
                repeat (mst_len) @(negedge clk);
                m_data_in = mst_rd; m_valid = mst_vld; m_busy = 1'b0; fall_cyc = cyc;
            end
        end
    end

    // s: 0 req_ack, 1 m_start high, 2 done, 3 m_start low
    task automatic wait_ev(input string nm, input int s, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((s == 0 && req_ack != 0) || (s == 1 && m_start) || (s == 2 && done != 0) || (s == 3 && !m_start)) begin
                at = cyc;
                return;
            end
        end
        n_chk++; n_fail++;
        $display("FAIL %s: no event within %0d cycles", nm, budget);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " m_start"}, 32'(m_start), 0);
        chk({nm, " m_addr"}, 32'(m_addr), 0);
        chk({nm, " m_rw"}, 32'(m_rw), 0);
        chk({nm, " m_bytes"}, 32'(m_bytes), 0);
        chk({nm, " m_wdata"}, m_wdata, 0);
        chk({nm, " req_ack"}, 32'(req_ack), 0);
        chk({nm, " done"}, 32'(done), 0);
        chk({nm, " rdata"}, rdata, 0);
        chk({nm, " rd_valid"}, 32'(rd_valid), 0);
        chk({nm, " timeout_err"}, 32'(timeout_err), 0);
    endtask

    task automatic set_slot(input int s, input logic [6:0] a, input logic rw, input logic [4:0] b, input logic [31:0] wd);
        req_addr[s*7 +: 7] = a;
        req_rw[s] = rw;
        req_bytes[s*5 +: 5] = b;
        req_wdata[s*32 +: 32] = wd;
    endtask

    int mptr = 0, last_ack_gap = 0;

    task automatic do_txn(input string nm, input int g, input logic [6:0] a, input logic rw, input logic [4:0] eb,
                          input logic [31:0] wd, input logic [31:0] erd, input logic erv, input int rereq, input int budget);
        int ta, ts, tf, td;
        logic [N-1:0] oh;
        oh = N'(1) << g;
        wait_ev({nm, " ack"}, 0, budget, ta);
        if (ta < 0) return;
        last_ack_gap = ta - fall_cyc;
        chk({nm, " req_ack"}, 32'(req_ack), 32'(oh));
        chk({nm, " m_addr"}, 32'(m_addr), 32'(a));
        chk({nm, " m_rw"}, 32'(m_rw), 32'(rw));
        chk({nm, " m_bytes"}, 32'(m_bytes), 32'(eb));
        chk({nm, " m_wdata"}, m_wdata, wd);
        req[g] = 1'b0;
        mptr = (g + 1) % N;
        wait_ev({nm, " start"}, 1, 50, ts);
        if (ts < 0) return;
        chk({nm, " ack->start"}, 32'(ts - ta), 1);
        wait_ev({nm, " start fall"}, 3, 50, tf);
        if (tf < 0) return;
        chk({nm, " busy rise->start fall"}, 32'(tf - rise_cyc), 3);
        wait_ev({nm, " done"}, 2, 100, td);
        if (td < 0) return;
        chk({nm, " done"}, 32'(done), 32'(oh));
        chk({nm, " busy fall->done"}, 32'(td - fall_cyc), 3);
        chk({nm, " rdata"}, rdata, erd);
        chk({nm, " rd_valid"}, 32'(rd_valid), 32'(erv));
        chk({nm, " timeout_err"}, 32'(timeout_err), 0);
        chk({nm, " m_addr hold"}, 32'(m_addr), 32'(a));
        if (rereq >= 0) req[rereq] = 1'b1;
    endtask

    typedef struct {
        int          slot;
        logic [6:0]  addr;
        logic        rw;
        logic [4:0]  bytes;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic [4:0]  exp_bytes;
        logic [31:0] exp_rdata;
        logic        exp_rv;
    } vec_t;

    vec_t tbl[6];
    int ord[6] = '{0, 1, 2, 3, 0, 2};
    int rr[6]  = '{0, -1, 2, -1, -1, -1};

    logic [6:0]  r_addr[N];
    logic        r_rw[N];
    logic [4:0]  r_bytes[N];
    logic [31:0] r_wd[N];

    initial begin
        int g, t;
        logic [N-1:0] pend;
        tbl[0] = '{1, 7'h48, 1'b0, 5'd2,  32'h0000_A55A, 32'hDEAD_BEEF, 5'd2, 32'h0,          1'b0};
        tbl[1] = '{0, 7'h50, 1'b1, 5'd2,  32'h0,         32'h0000_1234, 5'd2, 32'h0000_1234,  1'b1};
        tbl[2] = '{3, 7'h11, 1'b0, 5'd9,  32'h1122_3344, 32'h0,         5'd4, 32'h0,          1'b0};
        tbl[3] = '{2, 7'h7F, 1'b0, 5'd0,  32'h0,         32'hCAFE_F00D, 5'd0, 32'h0,          1'b0};
        tbl[4] = '{2, 7'h01, 1'b1, 5'd5,  32'h0,         32'hA1B2_C3D4, 5'd4, 32'hA1B2_C3D4,  1'b1};
        tbl[5] = '{0, 7'h3C, 1'b1, 5'd31, 32'hFFFF_FFFF, 32'h89AB_CDEF, 5'd4, 32'h89AB_CDEF,  1'b1};

        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        mptr = 0;

        for (int s = 0; s < N; s++) set_slot(s, 7'(16 + s), 1'b0, 5'd1, 32'(s));
        mst_rd = 32'h55; mst_vld = 1'b1;
        req = '1;
        for (int i = 0; i < 6; i++)
            do_txn($sformatf("fair%0d", i), ord[i], 7'(16 + ord[i]), 1'b0, 5'd1, 32'(ord[i]), 32'h0, 1'b0, rr[i], 50);

        for (int i = 0; i < 6; i++) begin
            set_slot(tbl[i].slot, tbl[i].addr, tbl[i].rw, tbl[i].bytes, tbl[i].wdata);
            mst_rd = tbl[i].rd; mst_vld = 1'b1; mst_len = 4; mst_dly = 1;
            req[tbl[i].slot] = 1'b1;
            do_txn($sformatf("vec%0d", i), tbl[i].slot, tbl[i].addr, tbl[i].rw, tbl[i].exp_bytes,
                   tbl[i].wdata, tbl[i].exp_rdata, tbl[i].exp_rv, -1, 50);
        end

        for (int k = 0; k < 25; k++) begin
            pend = N'($urandom_range(1, (1 << N) - 1));
            for (int s = 0; s < N; s++) begin
                r_addr[s] = 7'($urandom); r_rw[s] = 1'($urandom); r_bytes[s] = 5'($urandom); r_wd[s] = $urandom;
                set_slot(s, r_addr[s], r_rw[s], r_bytes[s], r_wd[s]);
            end
            req = pend;
            while (pend != 0) begin
                g = -1;
                for (int j = 0; j < N; j++)
                    if (g < 0 && pend[(mptr + j) % N]) g = (mptr + j) % N;
                mst_rd = $urandom; mst_vld = 1'($urandom_range(0, 1));
                mst_len = $urandom_range(3, 8); mst_dly = $urandom_range(0, 3);
                do_txn($sformatf("rand%0d.%0d", k, g), g, r_addr[g], r_rw[g], (r_bytes[g] > 5'd4) ? 5'd4 : r_bytes[g],
                       r_wd[g], r_rw[g] ? mst_rd : 32'h0, r_rw[g] & mst_vld, -1, 100);
                pend[g] = 1'b0;
            end
        end

        mst_len = 60; mst_dly = 1; mst_vld = 1'b1; mst_rd = 32'h0BAD_0BAD;
        set_slot(0, 7'h22, 1'b1, 5'd3, 32'h0);
        req[0] = 1'b1;
        wait_ev("rst ack", 0, 50, t);
        wait_ev("rst start", 1, 50, t);
        wait_ev("rst run", 3, 50, t);
        mst_len = 5;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero("mid-run reset");
        rst_n = 1'b1;
        mptr = 0;
        mst_rd = 32'h00C0_FFEE;
        do_txn("rst regrant", 0, 7'h22, 1'b1, 5'd3, 32'h0, 32'h00C0_FFEE, 1'b1, -1, 200);
        chk("rst busy fall->ack", 32'(last_ack_gap), 3);

`ifdef I2C_BUS_SCHEDULER_TIMEOUT_EN
        begin
            int ta, td;
            mst_len = 300; mst_dly = 1;
            set_slot(1, 7'h2A, 1'b1, 5'd2, 32'h0);
            req[1] = 1'b1;
            wait_ev("tmo ack", 0, 50, ta);
            req[1] = 1'b0;
            mptr = 2;
            wait_ev("tmo done", 2, 200, td);
            if (td >= 0) begin
                chk("tmo grant->done", 32'(td - ta), 32'(TMO));
                chk("tmo done", 32'(done), 32'h2);
                chk("tmo timeout_err", 32'(timeout_err), 1);
                chk("tmo rd_valid", 32'(rd_valid), 0);
                chk("tmo rdata", rdata, 0);
                chk("tmo m_start", 32'(m_start), 0);
            end
            for (int i = 0; i < 400 && m_busy; i++) @(negedge clk);
            repeat (4) @(negedge clk);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
